// File: rtl/data_mem_pkg.sv
// data_mem_pkg
// Shared definitions for the data memory controller: the controller state
// encoding, the memory Size/RW bus encodings and the byte sign-extension
// helper used when returning byte loads.
// Ports: none (package).
// Optional feature macro MEM_CTRL_SPLIT_EN is consumed by data_mem_ctrl,
// not by this package.

package data_mem_pkg;

    // Controller sequencing states. One state per memory bus phase.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RELEASE,
        WAIT,
        CAPTURE,
        RESP
    } state_t;

    // Memory Size encoding: one byte or one 32-bit big-endian word.
    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    // Memory RW encoding. The memory writes whenever RW is high.
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Widen a loaded byte to 32 bits, replicating bit 7 only for signed loads.
    function automatic logic [31:0] sext_byte(input logic [7:0] b, input logic sgn);
        return {{24{b[7] & sgn}}, b};
    endfunction

endpackage

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// Load/store master for the byte-addressed data memory. Takes one request at
// a time from the MEM stage, sequences the memory strobes so that RW is high
// for exactly one cycle with address/data/size already stable, and returns
// load data (zero- or sign-extended) through a valid/ready response.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_write, req_size, req_signed request kind: store, word, sign-extend
//   req_addr, req_wdata             byte address and store data
//   rsp_valid/rsp_ready             response handshake, held until taken
//   rsp_rdata, rsp_err              load data (0 for stores), reject flag
//   mem_a, mem_di, mem_size         memory Address, DataIn, Size
//   mem_rw, mem_e, mem_do           memory RW, Enable, DataOut
//
// Optional feature: define MEM_CTRL_SPLIT_EN to run misaligned word accesses
// as four sequential byte accesses instead of rejecting them.

module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int RD_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_di,
    input  logic [DATA_W-1:0] mem_do,
    output logic              mem_size,
    output logic              mem_rw,
    output logic              mem_e
);

`ifdef MEM_CTRL_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    // Highest address at which a whole word still fits inside the memory.
    localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'((2 ** ADDR_W) - 4);
    // WAIT counts down from this value to zero, giving RD_WAIT-1 cycles.
    localparam logic [1:0] WAIT_LOAD = 2'(RD_WAIT - 2);

    state_t      r_state;
    logic        r_write;
    logic        r_signed;
    logic        r_split;
    logic [1:0]  r_byteCnt;
    logic [1:0]  r_waitCnt;
    logic [31:0] r_wdata;

    logic w_misaligned;
    logic w_reject;
    logic w_split;

    // A word that runs past the end of memory is always rejected; a
    // misaligned word is rejected unless the split feature can break it
    // into byte accesses.
    assign w_misaligned = (req_addr[1:0] != 2'b00);
    assign w_reject     = (req_size == SIZE_WORD) &&
                          ((req_addr > LAST_WORD_ADDR) || (w_misaligned && !SPLIT_EN));
    assign w_split      = (req_size == SIZE_WORD) && w_misaligned;

    // Whole controller: state, byte counter, read-wait counter, store data
    // shift register and every output are registered here so the memory
    // bus never glitches. mem_rw is raised only on the SETUP->STROBE edge
    // and dropped on the next edge, so address/data/size are always settled
    // a cycle before and held a cycle after the write. For split accesses
    // the store data shifts left one byte per access so the next byte to
    // send is always in [23:16] after the first; load bytes shift into
    // rsp_rdata from the right, which leaves them big-endian after four.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            req_ready <= 1'b1;
            mem_rw    <= RW_READ;
            mem_e     <= 1'b0;
            mem_a     <= '0;
            mem_di    <= '0;
            mem_size  <= SIZE_BYTE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            r_write   <= 1'b0;
            r_signed  <= 1'b0;
            r_split   <= 1'b0;
            r_byteCnt <= 2'd0;
            r_waitCnt <= 2'd0;
            r_wdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        rsp_rdata <= '0;
                        r_write   <= req_write;
                        r_signed  <= req_signed;
                        r_split   <= w_split;
                        r_byteCnt <= 2'd0;
                        r_wdata   <= req_wdata;
                        if (w_reject) begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            r_state   <= RESP;
                        end else begin
                            rsp_err <= 1'b0;
                            mem_a   <= req_addr;
                            mem_e   <= 1'b1;
                            mem_rw  <= RW_READ;
                            if (w_split) begin
                                mem_size <= SIZE_BYTE;
                                mem_di   <= {24'h0, req_wdata[31:24]};
                            end else begin
                                mem_size <= req_size;
                                mem_di   <= req_wdata;
                            end
                            r_state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (r_write) begin
                        mem_rw  <= RW_WRITE;
                        r_state <= STROBE;
                    end else if (RD_WAIT > 1) begin
                        r_waitCnt <= WAIT_LOAD;
                        r_state   <= WAIT;
                    end else begin
                        r_state <= CAPTURE;
                    end
                end
                STROBE: begin
                    mem_rw  <= RW_READ;
                    r_state <= RELEASE;
                end
                RELEASE: begin
                    if (r_split && (r_byteCnt != 2'd3)) begin
                        r_byteCnt <= r_byteCnt + 2'd1;
                        mem_a     <= mem_a + 1'b1;
                        mem_di    <= {24'h0, r_wdata[23:16]};
                        r_wdata   <= {r_wdata[23:0], 8'h00};
                        r_state   <= SETUP;
                    end else begin
                        mem_e     <= 1'b0;
                        rsp_valid <= 1'b1;
                        r_state   <= RESP;
                    end
                end
                WAIT: begin
                    if (r_waitCnt == 2'd0) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_waitCnt <= r_waitCnt - 2'd1;
                    end
                end
                CAPTURE: begin
                    if (r_split) begin
                        rsp_rdata <= {rsp_rdata[23:0], mem_do[7:0]};
                        if (r_byteCnt != 2'd3) begin
                            r_byteCnt <= r_byteCnt + 2'd1;
                            mem_a     <= mem_a + 1'b1;
                            r_state   <= SETUP;
                        end else begin
                            mem_e     <= 1'b0;
                            rsp_valid <= 1'b1;
                            r_state   <= RESP;
                        end
                    end else begin
                        rsp_rdata <= (mem_size == SIZE_WORD) ? mem_do
                                                             : sext_byte(mem_do[7:0], r_signed);
                        mem_e     <= 1'b0;
                        rsp_valid <= 1'b1;
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        mem_e     <= 1'b0;
                        req_ready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
// Self-checking bench for data_mem_ctrl. A byte-array memory model sits on
// the memory bus; a reference byte image tracks what memory should hold and
// predicts every response from the request rules. Honors MEM_CTRL_SPLIT_EN
// the same way the design does.

module tb_data_mem_ctrl;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int RD_WAIT = 1;

`ifdef MEM_CTRL_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_size;
    logic        req_signed;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  mem_a;
    logic [31:0] mem_di;
    logic [31:0] mem_do;
    logic        mem_size;
    logic        mem_rw;
    logic        mem_e;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  memArr [256];
    logic [7:0]  refMem [256];
    bit          loadImage;
    bit          monEn;
    int          rwCount;
    int          eCount;
    logic [31:0] lastRdata;

    logic        prevRw;
    logic [31:0] prevAs;
    logic [31:0] prevDi;

    data_mem_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_WAIT(RD_WAIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_a     (mem_a),
        .mem_di    (mem_di),
        .mem_do    (mem_do),
        .mem_size  (mem_size),
        .mem_rw    (mem_rw),
        .mem_e     (mem_e)
    );

    always #5 clk = ~clk;

    // Memory model: writes whenever RW is high, big-endian words, byte
    // stores take DataIn[7:0]. During the first reset it loads the image.
    always @(posedge clk) begin
        if (mem_rw) begin
            if (mem_size) begin
                memArr[mem_a]        <= mem_di[31:24];
                memArr[mem_a + 8'd1] <= mem_di[23:16];
                memArr[mem_a + 8'd2] <= mem_di[15:8];
                memArr[mem_a + 8'd3] <= mem_di[7:0];
            end else begin
                memArr[mem_a] <= mem_di[7:0];
            end
        end else if (loadImage) begin
            for (int i = 0; i < 256; i++) memArr[i] <= refMem[i];
        end
    end

    assign mem_do = mem_size ? {memArr[mem_a], memArr[mem_a + 8'd1],
                                memArr[mem_a + 8'd2], memArr[mem_a + 8'd3]}
                             : {24'h0, memArr[mem_a]};

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Bus monitor: a write pulse must be one cycle wide with address, size
    // and data unchanged on the cycles before and after it.
    always @(negedge clk) begin
        if (monEn) begin
            if (mem_rw) begin
                rwCount++;
                checkOutput("rw_prev_low", 32'(prevRw), 32'd0);
                checkOutput("rw_addr_setup", {23'h0, mem_size, mem_a}, prevAs);
                checkOutput("rw_data_setup", mem_di, prevDi);
            end
            if (prevRw) begin
                checkOutput("rw_one_cycle", 32'(mem_rw), 32'd0);
                checkOutput("rw_addr_hold", {23'h0, mem_size, mem_a}, prevAs);
                checkOutput("rw_data_hold", mem_di, prevDi);
            end
            if (mem_e) eCount++;
        end
        prevRw = mem_rw;
        prevAs = {23'h0, mem_size, mem_a};
        prevDi = mem_di;
    end

    // Reference model: decides the outcome of one request from the access
    // rules and updates the expected memory image for stores.
    function automatic void modelRequest(input bit w, input bit sz, input bit sg,
                                         input logic [7:0] a, input logic [31:0] wd,
                                         output bit err, output logic [31:0] rd,
                                         output int strobes, output int lat);
        bit mis;
        bit split;
        mis     = (a % 4) != 0;
        err     = sz && ((int'(a) > 252) || (mis && !SPLIT));
        split   = sz && mis && !err;
        rd      = 32'h0;
        strobes = 0;
        lat     = 1;
        if (err) return;
        if (w) begin
            if (sz) begin
                for (int k = 0; k < 4; k++) refMem[8'(int'(a) + k)] = wd[31 - 8*k -: 8];
            end else begin
                refMem[a] = wd[7:0];
            end
            strobes = split ? 4 : 1;
            lat     = split ? 1 + 4 * 3 : 4;
        end else begin
            if (sz) begin
                for (int k = 0; k < 4; k++) rd = (rd << 8) | 32'(refMem[8'(int'(a) + k)]);
            end else begin
                rd = 32'(refMem[a]);
                if (sg && refMem[a] >= 8'd128) rd = rd + 32'hFFFFFF00;
            end
            lat = split ? 1 + 4 * (1 + RD_WAIT) : 2 + RD_WAIT;
        end
    endfunction

    // One full request/response. Entered and left just after a falling edge.
    task automatic applyStimulus(input bit w, input bit sz, input bit sg,
                                 input logic [7:0] a, input logic [31:0] wd,
                                 input int holdCycles);
        bit          expErr;
        logic [31:0] expRd;
        int          expStrobes;
        int          expLat;
        int          guard;
        int          edges;
        bit          done;
        modelRequest(w, sz, sg, a, wd, expErr, expRd, expStrobes, expLat);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard != 0) checkOutput("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        rwCount    = 0;
        eCount     = 0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        edges = 1;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (rsp_valid || edges >= 60) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                edges++;
            end
        end
        lastRdata = rsp_rdata;
        checkOutput("latency", 32'(edges), 32'(expLat));
        checkOutput("rsp_err", 32'(rsp_err), 32'(expErr));
        checkOutput("rsp_rdata", rsp_rdata, expRd);
        checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
        for (int h = 0; h < holdCycles; h++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_rdata", rsp_rdata, expRd);
            checkOutput("hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_drop", 32'(rsp_valid), 32'd0);
        checkOutput("idle_ready", 32'(req_ready), 32'd1);
        checkOutput("strobe_count", 32'(rwCount), 32'(expStrobes));
        if (expErr) checkOutput("err_no_enable", 32'(eCount), 32'd0);
    endtask

    // Watchdog so a stuck design can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  tmp;
        logic [31:0] wd;
        bit          w;
        bit          sz;
        bit          sg;
        logic [7:0]  a;
        int          guard;
        int          bad;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 1'b0;
        req_signed = 1'b0;
        req_addr   = 8'h00;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;
        monEn      = 1'b0;
        loadImage  = 1'b1;
        for (int i = 0; i < 256; i++) refMem[i] = 8'($urandom);
        refMem[8'h10] = 8'h8A;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ctrl", {27'h0, mem_rw, mem_e, rsp_valid, rsp_err, req_ready}, 32'h1);
        checkOutput("reset_addr_size", {23'h0, mem_size, mem_a}, 32'h0);
        checkOutput("reset_di", mem_di, 32'h0);
        checkOutput("reset_rdata", rsp_rdata, 32'h0);
        loadImage = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        monEn = 1'b1;

        $display("[TB] directed accesses");
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h10, 32'h0, 0);
        checkOutput("signed_byte_0x10", lastRdata, 32'hFFFFFF8A);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h10, 32'h0, 0);
        checkOutput("unsigned_byte_0x10", lastRdata, 32'h0000008A);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h20, 32'hDEADBEEF, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h20, 32'h0, 5);
        checkOutput("word_0x20", lastRdata, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h21, 32'h0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hFE, 32'h0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hFD, 32'h12345678, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h33, 32'hCAFEF00D, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h33, 32'h0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF, 32'hAAAAAA5C, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, 32'h0, 0);

        $display("[TB] random accesses");
        for (int n = 0; n < 40; n++) begin
            w   = 1'($urandom_range(0, 1));
            sz  = 1'($urandom_range(0, 1));
            sg  = 1'($urandom_range(0, 1));
            tmp = 8'($urandom);
            a   = ($urandom_range(0, 3) == 0) ? {tmp[7:2], 2'b00} : tmp;
            wd  = $urandom;
            applyStimulus(w, sz, sg, a, wd, $urandom_range(0, 2));
        end

        $display("[TB] reset during strobe");
        wd = $urandom;
        for (int k = 0; k < 4; k++) refMem[8'(8'h40 + k)] = wd[31 - 8*k -: 8];
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 1'b1;
        req_signed = 1'b0;
        req_addr   = 8'h40;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!mem_rw && guard < 10);
        checkOutput("strobe_seen", 32'(mem_rw), 32'd1);
        monEn = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_outputs", {28'h0, mem_rw, mem_e, rsp_valid, req_ready}, 32'h1);
        rst_n = 1'b1;
        @(negedge clk);
        monEn = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h40, 32'h0, 0);

        bad = 0;
        for (int i = 0; i < 256; i++) if (memArr[i] !== refMem[i]) bad++;
        checkOutput("mem_image_bad_bytes", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Initiator-side controller for the byte-addressed 256-byte data memory: the load/store master that drives DataIn, Address, Size, RW and Enable, and samples DataOut.
- Accepts one load/store request at a time from the MEM pipeline stage via a valid/ready handshake.
- Sequences safe memory strobes: the memory writes combinationally whenever RW=1 and ignores Enable, so this block keeps RW=1 for exactly one cycle with address and data already stable.
- Returns load data, zero- or sign-extended, through a valid/ready response.

Parameters:
- ADDR_W, 8, address width; memory depth is 2**ADDR_W bytes.
- DATA_W, 32, word width; fixed at 32 (4 bytes, big-endian).
- RD_WAIT, 1, cycles Address is held with RW=0 before DataOut is sampled (range 1..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_write  in  1  1=store, 0=load.
- req_size  in  1  0=byte, 1=word (memory Size encoding).
- req_signed  in  1  sign-extend byte loads.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; a byte store uses [7:0].
- rsp_valid  out  1  response held until rsp_ready.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  32  load data; 0 for stores.
- rsp_err  out  1  request rejected; no memory write occurred.
- mem_a  out  ADDR_W  memory Address.
- mem_di  out  32  memory DataIn.
- mem_do  in  32  memory DataOut.
- mem_size  out  1  memory Size.
- mem_rw  out  1  memory RW, 1=write.
- mem_e  out  1  memory Enable.

Behaviour:
- Reset (rst_n=0 at a rising edge) forces state IDLE and these outputs to 0: mem_rw, mem_e, mem_a, mem_di, mem_size, rsp_valid, rsp_rdata, rsp_err. req_ready=1 after reset.
- Reset mid-operation aborts the operation at the next edge. A split store that is aborted may leave earlier bytes written; this is accepted.
- FSM states: IDLE, SETUP, STROBE, RELEASE, WAIT, CAPTURE, RESP.
- IDLE: on req_valid&req_ready, register the request and go to SETUP.
  - Exception: a word request that is misaligned (addr[1:0]!=0) with MEM_CTRL_SPLIT_EN off, or with addr > 2**ADDR_W-4, goes directly to RESP with rsp_err=1. No strobe is issued.
- SETUP: mem_a, mem_size and mem_di are valid; mem_e=1; mem_rw=0.
  - Store: next state STROBE.
  - Load: next state WAIT if RD_WAIT>1, else CAPTURE.
- STROBE: mem_rw=1 for exactly one cycle; address and data unchanged. Next state RELEASE.
- RELEASE: mem_rw=0; address and data held one more cycle. Next state RESP.
- WAIT: counts RD_WAIT-1 cycles, then goes to CAPTURE.
- CAPTURE: sample mem_do.
  - Byte load: rdata = {{24{mem_do[7]&req_signed}}, mem_do[7:0]}.
  - Word load: rdata = mem_do.
  - Next state RESP.
- RESP: rsp_valid=1 with rsp_rdata and rsp_err held stable until rsp_ready=1. On that edge go to IDLE; rsp_valid falls.
- Exits from RESP and from RELEASE/CAPTURE clear mem_e to 0.
- Latency with RD_WAIT=1, from the accept edge to rsp_valid high:
  - load: 3 cycles
  - store: 4 cycles
  - error: 1 cycle
- Back-to-back requests: with rsp_ready tied high, a new request is accepted the cycle after the response completes (one IDLE cycle).
- mem_rw is never 1 outside STROBE. Address, data and Size change only while mem_rw=0.

Optional Feature:
- Macro: MEM_CTRL_SPLIT_EN.
- Defined: a misaligned word access runs as 4 sequential byte accesses at addr..addr+3, each through the full SETUP/STROBE/RELEASE (or SETUP/CAPTURE) sequence.
  - A 2-bit byte counter selects the byte: wdata[31:24] goes first.
  - Load bytes are assembled big-endian into rdata.
  - rsp_valid only after the 4th byte completes.
- Undefined: misaligned word access returns rsp_err=1 with no memory activity.
- Aligned words use a single word access in both cases.

Decomposition:
- Package data_mem_pkg holds:
  - the state enum
  - SIZE_BYTE=0, SIZE_WORD=1
  - RW_READ=0, RW_WRITE=1
  - function sext_byte
- No sub-module. The FSM, byte counter and assembly register live in one module. The existing memory model is instantiated only in the bench.

Test Plan:
- Memory preloaded with 0x8A at address 0x10; signed byte load from 0x10 -> rsp_rdata=0xFFFFFF8A 3 cycles after accept. Unsigned byte load -> 0x0000008A.
- Word store 0xDEADBEEF to 0x20, then word load from 0x20 -> rsp_rdata=0xDEADBEEF. Memory bytes 0x20..0x23 = DE AD BE EF. mem_rw high exactly 1 cycle, with mem_a stable on the cycles before and after.
- Word load from 0x21 -> without MEM_CTRL_SPLIT_EN: rsp_err=1, rsp_rdata=0, mem_e never asserted. With the macro: 4 byte reads, result big-endian from bytes 0x21..0x24.
- Word load from 0xFE -> rsp_err=1 in both builds; no strobe.
- Hold rsp_ready=0 for 5 cycles during a load -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; on release, the next request is accepted after one IDLE cycle.
- Assert rst_n=0 during STROBE -> next edge mem_rw=0, mem_e=0, rsp_valid=0, req_ready=1.
